// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a word-serial refill FSM.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module l1_dcache #(
  parameter int ADDR_W      = 10,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              stall,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int K_W   = (OFF_W < 2) ? 2 : OFF_W;
  localparam int LW_W  = IDX_W + OFF_W;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state_q;
  logic [K_W-1:0]    k_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS*BLOCK_WORDS];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              hit, load, idle, miss_start, fill_last;
  logic [LW_W-1:0]   fill_word;

  assign {req_tag, req_idx, req_off} = cpu_addr;
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign load       = cpu_ren && !cpu_wen;
  assign idle       = (state_q == IDLE);
  assign miss_start = idle && load && !hit;
  assign fill_last  = (state_q == FILL) && (k_q == K_W'(BLOCK_WORDS - 1));
  assign fill_word  = {fill_idx_q, k_q[OFF_W-1:0]};

  // Outputs are combinational but forced to zero whenever reset is held low.
  always_comb begin
    stall    = 1'b0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    cpu_dout = '0;
    if (reset) begin
      if (!idle) begin
        stall    = 1'b1;
        mem_ren  = 1'b1;
        mem_addr = {fill_tag_q, fill_idx_q, k_q[OFF_W-1:0]};
      end else if (cpu_wen) begin
        mem_wen  = 1'b1;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
      end else if (cpu_ren) begin
        if (hit) cpu_dout = data_q[{req_idx, req_off}];
        else     stall    = 1'b1;
      end
    end
  end

  // Fill address is latched at the miss so a request change cannot redirect the refill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      valid_q    <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q    <= FILL;
            k_q        <= '0;
            fill_tag_q <= req_tag;
            fill_idx_q <= req_idx;
          end
        end
        FILL: begin
          k_q <= k_q + K_W'(1);
          if (fill_last) begin
            state_q             <= IDLE;
            k_q                 <= '0;
            valid_q[fill_idx_q] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clock) begin
    if (state_q == FILL) begin
      data_q[fill_word] <= mem_dout;
      if (fill_last) tag_q[fill_idx_q] <= fill_tag_q;
    end else if (reset && cpu_wen && hit) begin
      data_q[{req_idx, req_off}] <= cpu_din;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (load && !stall) hit_q  <= hit_q + 32'd1;
      if (miss_start)     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache with a Dmem model and a load-data scoreboard.
// Hit/miss counters are also checked when DCACHE_STATS_EN is defined.
module tb_l1_dcache;

  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_ren = 1'b0;
  logic              cpu_wen = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_din = '0;
  logic [31:0]       cpu_dout;
  logic              stall;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
`endif

  logic [31:0] dmem [1024];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  l1_dcache #(.ADDR_W(ADDR_W), .SETS(16), .BLOCK_WORDS(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .stall(stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  assign mem_dout = dmem[mem_addr];
  always @(posedge clock) if (mem_wen) dmem[mem_addr] <= mem_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every presented load result is matched against the scoreboard queue.
  always @(negedge clock) begin
    if (reset && mem_ren && mem_wen) begin
      errors++;
      $display("FAIL mem_excl: mem_ren and mem_wen both high");
    end
    if (reset && cpu_ren && !cpu_wen && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: got 0x%08h expected no load result", cpu_dout);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (cpu_dout !== e) begin
          errors++;
          $display("FAIL load_data @0x%03h: got 0x%08h expected 0x%08h", cpu_addr, cpu_dout, e);
        end
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [31:0] d, input int exp_stall);
    int n;
    logic [ADDR_W-1:0] fa;
    @(posedge clock); #1;
    cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = a;
    exp_q.push_back(d);
    n = 0;
    forever begin
      @(negedge clock);
      if (!stall) break;
      if (n >= 1 && n <= 4) begin
        fa = {a[ADDR_W-1:2], 2'(n - 1)};
        check("fill_mem_addr", 32'(mem_addr), 32'(fa));
        check("fill_mem_ren", 32'(mem_ren), 32'd1);
      end
      n++;
      if (n > 30) break;
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge clock); #1;
    cpu_ren = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    cpu_wen = 1'b1; cpu_ren = 1'b0; cpu_addr = a; cpu_din = d;
    @(negedge clock);
    check("wr_mem_wen", 32'(mem_wen), 32'd1);
    check("wr_mem_ren", 32'(mem_ren), 32'd0);
    check("wr_mem_addr", 32'(mem_addr), 32'(a));
    check("wr_mem_din", mem_din, d);
    check("wr_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
    cpu_wen = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
    check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, mem_din, 32'd0);
    check({tag, "_cpu_dout"}, cpu_dout, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = 32'h1000 + 32'(i);

    // Reset held with a pending load: every output must stay at zero.
    cpu_ren = 1'b1; cpu_addr = 10'h004;
    repeat (2) @(negedge clock);
    check_outputs_zero("rst");
`ifdef DCACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    cpu_ren = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check_outputs_zero("idle");

    // Cold miss then hit in the same line.
    do_read(10'h004, 32'h0000_1004, 5);
    do_read(10'h006, 32'h0000_1006, 0);
`ifdef DCACHE_STATS_EN
    check("cold_miss_count", miss_count, 32'd1);
    check("cold_hit_count", hit_count, 32'd2);
`endif

    // Write hit updates cache and memory.
    do_write(10'h005, 32'hDEAD_BEEF);
    check("wr_hit_dmem", dmem[10'h005], 32'hDEAD_BEEF);
    do_read(10'h005, 32'hDEAD_BEEF, 0);

    // Write miss does not allocate.
    do_write(10'h100, 32'h1234_5678);
    check("wr_miss_dmem", dmem[10'h100], 32'h1234_5678);
    do_read(10'h100, 32'h1234_5678, 5);

    // Conflict on index 1.
    do_read(10'h044, 32'h0000_1044, 5);
    do_read(10'h004, 32'h0000_1004, 5);
    do_read(10'h005, 32'hDEAD_BEEF, 0);
`ifdef DCACHE_STATS_EN
    check("conf_miss_count", miss_count, 32'd4);
`endif

    // Reset during the second fill cycle aborts the refill.
    @(posedge clock); #1;
    cpu_ren = 1'b1; cpu_addr = 10'h044;
    @(negedge clock);
    check("mf_detect_stall", 32'(stall), 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("mf_mem_ren", 32'(mem_ren), 32'd1);
    check("mf_mem_addr", 32'(mem_addr), 32'h045);
    #1 reset = 1'b0;
    #1;
    check_outputs_zero("mf_rst");
    cpu_ren = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
`ifdef DCACHE_STATS_EN
    check("mf_miss_count", miss_count, 32'd0);
`endif
    do_read(10'h004, 32'h0000_1004, 5);
    do_read(10'h044, 32'h0000_1044, 5);
    do_read(10'h047, 32'h0000_1047, 0);
`ifdef DCACHE_STATS_EN
    check("end_miss_count", miss_count, 32'd2);
    check("end_hit_count", hit_count, 32'd3);
`endif

    repeat (2) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
